dmem_responder: RTL and testbench

Memory-side responder for the pipelined CPU's data-memory port. It takes the CPU's memRead/memWrite requests from the EX/MEM stage and serves them from an internal word array after a configurable access latency. While an access is in flight it raises a stall to freeze the pipeline, then returns load data for exactly one release cycle. It replaces the zero-latency combinational data memory and lets the pipeline be exercised against realistic memory timing.

---
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder.sv | 102 ++++++++++
 tb/tb_dmem_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory port between the CPU's EX/MEM stage and the latency-modelling responder.
// Signal names are from the responder's point of view.
interface dmem_responder_if;
   logic        memRead_i;
   logic        memWrite_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        stall_o;
   logic        done_o;
   logic        err_o;

   modport master (
      output memRead_i, memWrite_i, addr_i, wdata_i,
      input  rdata_o, stall_o, done_o, err_o
   );

   modport slave (
      input  memRead_i, memWrite_i, addr_i, wdata_i,
      output rdata_o, stall_o, done_o, err_o
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: serves CPU loads/stores from a word array after LATENCY busy
// cycles, stalling the pipeline meanwhile and pulsing done_o in the release cycle.
module dmem_responder #(
   parameter int DEPTH   = 32,
   parameter int LATENCY = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   dmem_responder_if.slave   bus
);
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_q;
   logic [3:0]         cnt_q;
   logic               op_write_q;
   logic [IDX_W-1:0]   idx_q;
   logic [31:0]        wdata_q;
   logic [31:0]        rdata_q;
   logic               done_q;
   logic               err_q;
   logic [31:0]        mem_q [DEPTH];

   logic               req;
   logic               access;
   logic [IDX_W-1:0]   idx_d;
   logic               unused_addr;

   assign req    = bus.memRead_i | bus.memWrite_i;
   assign access = (state_q == BUSY) && (cnt_q == 4'd0);
   assign idx_d  = bus.addr_i[IDX_W+1:2];

   // Upper address bits wrap and byte offset bits are ignored.
   assign unused_addr = ^{bus.addr_i[31:IDX_W+2], bus.addr_i[1:0]};

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_write_q <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (req) begin
                  // A simultaneous read+write is serviced as a write and flagged.
                  op_write_q <= bus.memWrite_i;
                  idx_q      <= idx_d;
                  wdata_q    <= bus.wdata_i;
                  cnt_q      <= 4'(LATENCY - 1);
                  state_q    <= BUSY;
                  if (bus.memRead_i && bus.memWrite_i) begin
                     err_q <= 1'b1;
                  end
               end
            end
            BUSY: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  if (!op_write_q) begin
                     rdata_q <= mem_q[idx_q];
                  end
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               // The CPU still presents the finished request here, so it is ignored.
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (access && op_write_q) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   // Stall asserts combinationally on a fresh request and drops as soon as reset is applied.
   assign bus.stall_o = rst_i & (((state_q == IDLE) & req) | (state_q == BUSY));
   assign bus.done_o  = done_q;
   assign bus.rdata_o = rdata_q;
   assign bus.err_o   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed checks of dmem_responder against a word-array reference model.
module tb_dmem_responder;
   localparam int DEPTH = 32;
   localparam int LAT   = 2;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [31:0] ref_mem [DEPTH];
   logic [31:0] ref_rdata;
   logic        ref_err;

   dmem_responder_if bus ();

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      ref_rdata = '0;
      ref_err   = 1'b0;
   endtask

   // One complete access: request held through DONE, inputs scrambled while BUSY.
   task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input string tag);
      int unsigned idx;
      idx = (addr / 4) % DEPTH;
      @(negedge clk);
      bus.memRead_i  = rd;
      bus.memWrite_i = wr;
      bus.addr_i     = addr;
      bus.wdata_i    = data;
      #1;
      chk({tag, " stall c0"}, 32'(bus.stall_o), 32'd1);
      chk({tag, " done c0"}, 32'(bus.done_o), 32'd0);
      if (rd && wr) ref_err = 1'b1;
      if (wr) ref_mem[idx] = data;
      else    ref_rdata = ref_mem[idx];
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         bus.memRead_i  = 1'($urandom);
         bus.memWrite_i = 1'($urandom);
         bus.addr_i     = $urandom;
         bus.wdata_i    = $urandom;
         #1;
         chk({tag, " stall busy"}, 32'(bus.stall_o), 32'd1);
         chk({tag, " done busy"}, 32'(bus.done_o), 32'd0);
      end
      @(negedge clk);
      bus.memRead_i  = rd;
      bus.memWrite_i = wr;
      bus.addr_i     = addr;
      bus.wdata_i    = data;
      #1;
      chk({tag, " done pulse"}, 32'(bus.done_o), 32'd1);
      chk({tag, " stall done"}, 32'(bus.stall_o), 32'd0);
      chk({tag, " rdata"}, bus.rdata_o, ref_rdata);
      chk({tag, " err"}, 32'(bus.err_o), 32'(ref_err));
      bus.memRead_i  = 1'b0;
      bus.memWrite_i = 1'b0;
      @(negedge clk);
      #1;
      chk({tag, " idle stall"}, 32'(bus.stall_o), 32'd0);
      chk({tag, " idle done"}, 32'(bus.done_o), 32'd0);
      $display("access %s rd=%0d wr=%0d addr=%h wdata=%h rdata=%h err=%0d",
               tag, rd, wr, addr, data, bus.rdata_o, bus.err_o);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      model_reset();
      rst_n          = 1'b0;
      bus.memRead_i  = 1'b0;
      bus.memWrite_i = 1'b0;
      bus.addr_i     = '0;
      bus.wdata_i    = '0;
      #3;
      chk("reset rdata", bus.rdata_o, 32'd0);
      chk("reset stall", 32'(bus.stall_o), 32'd0);
      chk("reset done", 32'(bus.done_o), 32'd0);
      chk("reset err", 32'(bus.err_o), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      do_access(1'b1, 1'b0, 32'h40, 32'h0, "rd40");
      do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10");
      do_access(1'b1, 1'b0, 32'h10, 32'h0, "rd10");
      do_access(1'b1, 1'b0, 32'h08, 32'h0, "held08");
      do_access(1'b0, 1'b1, 32'h84, 32'h12345678, "wr84");
      do_access(1'b1, 1'b0, 32'h04, 32'h0, "rd04");
      do_access(1'b1, 1'b0, 32'h07, 32'h0, "rd07");
      do_access(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, "both20");
      do_access(1'b1, 1'b0, 32'h20, 32'h0, "rd20");

      // Reset during the first BUSY cycle of a write.
      @(negedge clk);
      bus.memRead_i  = 1'b0;
      bus.memWrite_i = 1'b1;
      bus.addr_i     = 32'h30;
      bus.wdata_i    = 32'h55;
      @(negedge clk);
      #1;
      chk("midrst busy stall", 32'(bus.stall_o), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst stall", 32'(bus.stall_o), 32'd0);
      chk("midrst done", 32'(bus.done_o), 32'd0);
      chk("midrst err", 32'(bus.err_o), 32'd0);
      chk("midrst rdata", bus.rdata_o, 32'd0);
      model_reset();
      @(negedge clk);
      bus.memWrite_i = 1'b0;
      rst_n = 1'b1;
      $display("access midrst wr addr=00000030 wdata=00000055 aborted");
      do_access(1'b1, 1'b0, 32'h30, 32'h0, "rd30");

      for (int n = 0; n < 40; n++) begin
         bit          rd;
         bit          wr;
         int unsigned sel;
         logic [31:0] a;
         sel = $urandom_range(0, 9);
         rd  = (sel < 5) || (sel == 9);
         wr  = (sel >= 5);
         a   = {$urandom_range(0, 3) == 0 ? 25'($urandom) : 25'd0, 7'($urandom)};
         do_access(rd, wr, a, $urandom, "rand");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
